mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multicycle control FSM that sequences the shared ALU, register file, memory port and PC for the MIPS-subset core.
- Decodes the held instruction word and drives ALU operand selects and the 4-bit ALU control code.
- Drives register/memory/PC enables and waits on a memory-ready handshake.
- Also counts retired instructions and flags illegal encodings.

Parameters:
CNT_W, 32, width of retire counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
instr  in  32  IR contents; opcode [31:26], funct [5:0]; stable outside FETCH
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  0=PC address, 1=ALUOut address
ir_write  out  1  load IR
pc_en  out  1  PC load = pc_write | (branch & zero)
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
reg_write  out  1  register file write
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
illegal  out  1  one-cycle pulse on undecodable instruction
state  out  4  current state code (debug)
retire_cnt  out  CNT_W  retired instruction count

Behaviour:
- Moore outputs decode combinationally from the state register and instr; pc_en also uses zero. Unlisted outputs are 0 in each state.
- rst low at a clock edge: state <= IDLE(0), retire_cnt <= 0. This overrides everything, including an in-flight memory access, which is abandoned.
- In IDLE all outputs are 0, state=0, illegal=0.
- State codes and outputs:
  - IDLE(0): outputs all 0; next FETCH.
  - FETCH(1): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=0010, pc_src=00; ir_write=pc_write=mem_ready. Hold in FETCH until mem_ready=1, then DECODE.
  - DECODE(2): alu_src_a=0, alu_src_b=11, alu_ctrl=0010. Next by opcode:
    - 000000 -> EXEC
    - 100011/101011 -> MEMADR
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - other -> FETCH with illegal=1
  - MEMADR(3): alu_src_a=1, alu_src_b=10, ADD. Next: lw -> MEMRD, sw -> MEMWR.
  - MEMRD(4): mem_read=1, iord=1. Hold until mem_ready, then MEMWB.
  - MEMWB(5): reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
  - MEMWR(6): mem_write=1, iord=1. Hold until mem_ready, then FETCH.
  - EXEC(7): alu_src_a=1, alu_src_b=00. alu_ctrl by funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111. Next ALUWB.
  - ALUWB(8): reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
  - BRANCH(9): alu_src_a=1, alu_src_b=00, alu_ctrl=0110, branch=1, pc_src=01. Next FETCH.
  - ADDIEX(10): alu_src_a=1, alu_src_b=10, ADD. Next ADDIWB.
  - ADDIWB(11): reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
  - JUMP(12): see Optional Feature.
- R-type with an unlisted funct: detected in DECODE; illegal=1, next FETCH, EXEC never entered.
- Illegal instructions are not counted as retired. The PC has already advanced by 4 in FETCH.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR. It may stay low indefinitely; mem_read/mem_write stay asserted while waiting.
- retire_cnt increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. It wraps from all-ones to 0.
- Cycle counts with mem_ready tied high: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
- Unused state codes 13-15 go to IDLE on the next edge; retire_cnt is unchanged.

Optional Feature:
- Macro MC_JUMP_EN.
- Defined: opcode 000010 in DECODE -> JUMP(12). JUMP drives pc_src=10, pc_write=1 (pc_en=1), then FETCH and counts as retired.
- Undefined: opcode 000010 is illegal, state 12 is unused (treated like 13-15), and pc_src never takes 10.

Test Plan:
- Reset: hold rst=0 for 3 cycles with mem_ready=1 -> state=0, all outputs 0, retire_cnt=0. Release -> FETCH next cycle.
- R-type: add (funct 100000), mem_ready=1 -> states 1,2,7,8,1. alu_ctrl=0010 in EXEC, reg_write=1/reg_dst=1 in ALUWB, retire_cnt=1. Repeat for sub/and/or/slt expecting 0110/0000/0001/0111.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEMRD: mem_read held high throughout, ir_write pulses only on the ready cycle. Total 10 cycles, mem_to_reg=1 in MEMWB.
- beq: zero=1 in BRANCH -> pc_en=1, pc_src=01, alu_ctrl=0110. zero=0 -> pc_en=0. Both retire.
- Illegal: opcode 111111, then R-type funct 000000 -> illegal=1 in DECODE, next FETCH, retire_cnt unchanged.
- Reset in MEMWR with mem_ready=0 -> next state 0 and mem_write=0. With MC_JUMP_EN, j -> pc_src=10 in state 12; without it -> illegal=1.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-subset core: sequences ALU, register file, memory and PC.
// Optional jump support (opcode 000010, state 12) is enabled by defining MC_JUMP_EN.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
`ifdef MC_JUMP_EN
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [3:0] state_q, state_d;
  logic [5:0] opcode, funct;
  logic       funct_ok;
  logic [3:0] rtype_alu;
  logic       pc_write, branch, retire;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];
  assign state        = state_q;

  // R-type funct decode; unlisted functs are rejected in DECODE
  always_comb begin
    funct_ok  = 1'b1;
    rtype_alu = ALU_ADD;
    case (funct)
      FN_ADD:  rtype_alu = ALU_ADD;
      FN_SUB:  rtype_alu = ALU_SUB;
      FN_AND:  rtype_alu = ALU_AND;
      FN_OR:   rtype_alu = ALU_OR;
      FN_SLT:  rtype_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and Moore output decode; retire marks a completing instruction
  always_comb begin
    state_d    = S_IDLE;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_AND;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_EXEC;
            end else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = rtype_alu;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        branch    = 1'b1;
        pc_src    = 2'b01;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    pc_en = pc_write | (branch & zero);
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst)        retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed and random instructions against a per-class path model.
module tb_mc_ctrl;
  localparam int unsigned CW = 4;
  localparam int ADD = 2;
  localparam int SUB = 6;

  typedef enum int {C_R, C_LW, C_SW, C_BEQ, C_ADDI, C_J, C_ILL} cls_t;

  logic          clk = 1'b0;
  logic          rst, zero, mem_ready;
  logic [31:0]   instr;
  logic          mem_read, mem_write, iord, ir_write, pc_en;
  logic [1:0]    pc_src, alu_src_b;
  logic          alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0]    alu_ctrl, state;
  logic [CW-1:0] retire_cnt;
  logic [17:0]   obs;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cnt   = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state), .retire_cnt(retire_cnt)
  );

  assign obs = {mem_read, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
                alu_src_b, alu_ctrl, reg_write, reg_dst, mem_to_reg, illegal};

  function automatic logic [17:0] mk(input int mr, mw, io, irw, pce, ps, asa, asb, ac,
                                     rw, rd, m2r, ill);
    return {1'(mr), 1'(mw), 1'(io), 1'(irw), 1'(pce), 2'(ps), 1'(asa), 2'(asb),
            4'(ac), 1'(rw), 1'(rd), 1'(m2r), 1'(ill)};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cls_t classify(input logic [31:0] ins);
    cls_t c;
    c = C_ILL;
    case (ins[31:26])
      6'b000000: if (ins[5:0] inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) c = C_R;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b000100: c = C_BEQ;
      6'b001000: c = C_ADDI;
`ifdef MC_JUMP_EN
      6'b000010: c = C_J;
`endif
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic int r_code(input logic [5:0] fn);
    case (fn)
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return 2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance past the next rising edge
  task automatic step(input int est, input logic rdy, input logic z, input logic [17:0] eo);
    mem_ready = rdy;
    zero      = z;
    @(negedge clk);
    check($sformatf("state@st%0d", est), 32'(state), 32'(est));
    check($sformatf("outs@st%0d", est), 32'(obs), 32'(eo));
    @(posedge clk);
    #1;
  endtask

  // Expected walk for one instruction, starting with the DUT in FETCH
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int bz);
    cls_t c;
    logic z;
    c = classify(ins);
    instr = ins;
    for (int i = 0; i < fw; i++) step(1, 1'b0, rb(), mk(1,0,0,0,0,0,0,1,ADD,0,0,0,0));
    step(1, 1'b1, rb(), mk(1,0,0,1,1,0,0,1,ADD,0,0,0,0));
    step(2, rb(), rb(), mk(0,0,0,0,0,0,0,3,ADD,0,0,0,(c == C_ILL) ? 1 : 0));
    case (c)
      C_R: begin
        step(7, rb(), rb(), mk(0,0,0,0,0,0,1,0,r_code(ins[5:0]),0,0,0,0));
        step(8, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,1,0,0));
      end
      C_LW: begin
        step(3, rb(), rb(), mk(0,0,0,0,0,0,1,2,ADD,0,0,0,0));
        for (int i = 0; i < mw; i++) step(4, 1'b0, rb(), mk(1,0,1,0,0,0,0,0,0,0,0,0,0));
        step(4, 1'b1, rb(), mk(1,0,1,0,0,0,0,0,0,0,0,0,0));
        step(5, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,0,1,0));
      end
      C_SW: begin
        step(3, rb(), rb(), mk(0,0,0,0,0,0,1,2,ADD,0,0,0,0));
        for (int i = 0; i < mw; i++) step(6, 1'b0, rb(), mk(0,1,1,0,0,0,0,0,0,0,0,0,0));
        step(6, 1'b1, rb(), mk(0,1,1,0,0,0,0,0,0,0,0,0,0));
      end
      C_BEQ: begin
        z = (bz < 0) ? rb() : 1'(bz);
        step(9, rb(), z, mk(0,0,0,0,z,1,1,0,SUB,0,0,0,0));
      end
      C_ADDI: begin
        step(10, rb(), rb(), mk(0,0,0,0,0,0,1,2,ADD,0,0,0,0));
        step(11, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,0,0,0));
      end
      C_J: step(12, rb(), rb(), mk(0,0,0,0,1,2,0,0,0,0,0,0,0));
      default: ;
    endcase
    if (c != C_ILL) cnt = cnt + 1;
    check("retire_cnt", 32'(retire_cnt), 32'(CW'(cnt)));
    check("state_end", 32'(state), 32'd1);
  endtask

  initial begin
    logic [31:0] r, ins;
    logic [5:0]  fn;
    logic [5:0]  fns [5];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst = 1'b0; mem_ready = 1'b1; zero = 1'b0; instr = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b1, 1'b0, '0);
      check("retire_rst", 32'(retire_cnt), 32'd0);
    end
    rst = 1'b1;
    step(0, 1'b1, 1'b0, '0);
    check("state_after_release", 32'(state), 32'd1);

    // Directed: each R-type op, stalled lw, both beq outcomes, illegal forms, jump
    for (int i = 0; i < 5; i++) run_instr({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, fns[i]}, 0, 0, -1);
    run_instr({6'b100011, 5'd1, 5'd2, 16'h0004}, 3, 2, -1);
    run_instr({6'b101011, 5'd1, 5'd2, 16'h0008}, 0, 0, -1);
    run_instr({6'b000100, 5'd1, 5'd2, 16'hfffe}, 0, 0, 1);
    run_instr({6'b000100, 5'd1, 5'd2, 16'h0003}, 0, 0, 0);
    run_instr({6'b001000, 5'd1, 5'd2, 16'h0010}, 0, 0, -1);
    run_instr({6'b111111, 26'h0}, 0, 0, -1);
    run_instr({6'b000000, 20'h12345, 6'b000000}, 0, 0, -1);
    run_instr({6'b000010, 26'h0000123}, 0, 0, -1);

    // Random mix, long enough for the narrow counter to wrap several times
    for (int n = 0; n < 150; n++) begin
      r = $urandom();
      case ($urandom_range(0, 7))
        0: ins = {6'b000000, r[25:6], fns[$urandom_range(0, 4)]};
        1: ins = {6'b100011, r[25:0]};
        2: ins = {6'b101011, r[25:0]};
        3: ins = {6'b000100, r[25:0]};
        4: ins = {6'b001000, r[25:0]};
        5: ins = {6'b000010, r[25:0]};
        6: begin
          ins = r;
          if (classify(ins) != C_ILL) ins[31:26] = 6'b111111;
        end
        default: begin
          fn = r[5:0];
          if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) fn = 6'b000001;
          ins = {6'b000000, r[25:6], fn};
        end
      endcase
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    // Reset while a store is stalled in MEMWR
    instr = {6'b101011, 5'd3, 5'd4, 16'h0020};
    step(1, 1'b1, 1'b0, mk(1,0,0,1,1,0,0,1,ADD,0,0,0,0));
    step(2, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,3,ADD,0,0,0,0));
    step(3, 1'b0, 1'b0, mk(0,0,0,0,0,0,1,2,ADD,0,0,0,0));
    step(6, 1'b0, 1'b0, mk(0,1,1,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b0;
    step(6, 1'b0, 1'b0, mk(0,1,1,0,0,0,0,0,0,0,0,0,0));
    cnt = 0;
    step(0, 1'b0, 1'b0, '0);
    check("retire_after_abort", 32'(retire_cnt), 32'd0);
    rst = 1'b1;
    step(0, 1'b0, 1'b0, '0);
    check("state_after_abort", 32'(state), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
